// File: rtl/bus_trace_fifo.sv
// Bus trace capture stage for a 6502 core.
// It samples the CPU pins once per CPU cycle, on the falling edge of PHI2, and can wait for an
// opcode-fetch trigger. It stores a bounded run of cycles in a first-word-fall-through FIFO
// that a debugger drains through a valid/ready port.
module bus_trace_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  PHI0,
  input  logic                  RES,
  input  logic                  PHI2,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  input  logic                  RnW,
  input  logic                  SYNC,
  input  logic                  ARM,
  input  logic                  ABORT,
  input  logic                  TRIG_EN,
  input  logic [15:0]           TRIG_ADDR,
  input  logic [7:0]            POST_CNT,
  output logic [25:0]           OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullLevel = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e                state_q, state_d;
  logic                  phi2_q;
  logic [8:0]            remaining_q, remaining_d;
  logic [25:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  ovf_q;

  logic        cap;
  logic        trig_hit;
  logic [25:0] entry;
  logic        push_req;
  logic        flush;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        ovf_set;

  assign cap      = phi2_q & ~PHI2;
  assign entry    = {SYNC, RnW, A, D};
  assign trig_hit = cap & SYNC & (A == TRIG_ADDR);
  assign full     = (level_q == FullLevel);
  assign pop      = (level_q != '0) & OUT_READY;
  // A push into a full FIFO still lands if the head leaves in the same cycle
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  // State, cycle counter and PHI2 edge-detect register
  always_ff @(posedge PHI0) begin
    if (RES) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      phi2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      phi2_q      <= PHI2;
    end
  end

  // Next-state and push/flush decisions; ABORT beats ARM, and both suppress a coincident cap
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    push_req    = 1'b0;
    flush       = 1'b0;
    if (ABORT) begin
      state_d = StIdle;
    end else if (ARM) begin
      flush       = 1'b1;
      state_d     = TRIG_EN ? StArmed : StCapture;
      remaining_d = {1'b0, POST_CNT} + 9'd1;
    end else begin
      unique case (state_q)
        StArmed: begin
          if (trig_hit) begin
            push_req = 1'b1;
            if (POST_CNT == 8'd0) begin
              state_d = StDone;
            end else begin
              state_d     = StCapture;
              remaining_d = {1'b0, POST_CNT};
            end
          end
        end
        StCapture: begin
          // Counts CPU cycles, so dropped entries still consume the budget
          if (cap) begin
            push_req    = 1'b1;
            remaining_d = remaining_q - 9'd1;
            if (remaining_q == 9'd1) state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge PHI0) begin
    if (RES || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (!push_ok && pop) begin
        level_q <= level_q - 1'b1;
      end
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Entry storage; no reset needed since OUT_DATA is masked while empty
  always_ff @(posedge PHI0) begin
    if (!RES && !flush && push_ok) mem_q[wr_ptr_q] <= entry;
  end

  // Status and head outputs
  always_comb begin
    BUSY      = (state_q == StArmed) || (state_q == StCapture);
    DONE      = (state_q == StDone);
    OUT_VALID = (level_q != '0);
    OUT_DATA  = OUT_VALID ? mem_q[rd_ptr_q] : 26'd0;
    LEVEL     = level_q;
    OVF       = ovf_q;
  end

endmodule

// File: tb/tb_bus_trace_fifo.sv
// Self-checking bench for bus_trace_fifo: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the capture rules.
module tb_bus_trace_fifo;

  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned Depth     = 1 << DepthLog2;

  logic                 PHI0 = 1'b0;
  logic                 RES = 1'b1;
  logic                 PHI2 = 1'b0;
  logic [15:0]          A = '0;
  logic [7:0]           D = '0;
  logic                 RnW = 1'b1;
  logic                 SYNC = 1'b0;
  logic                 ARM = 1'b0;
  logic                 ABORT = 1'b0;
  logic                 TRIG_EN = 1'b0;
  logic [15:0]          TRIG_ADDR = '0;
  logic [7:0]           POST_CNT = '0;
  logic [25:0]          OUT_DATA;
  logic                 OUT_VALID;
  logic                 OUT_READY = 1'b0;
  logic [DepthLog2:0]   LEVEL;
  logic                 BUSY;
  logic                 DONE;
  logic                 OVF;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  bus_trace_fifo #(.DEPTH_LOG2(DepthLog2)) dut (
    .PHI0(PHI0), .RES(RES), .PHI2(PHI2), .A(A), .D(D), .RnW(RnW), .SYNC(SYNC),
    .ARM(ARM), .ABORT(ABORT), .TRIG_EN(TRIG_EN), .TRIG_ADDR(TRIG_ADDR),
    .POST_CNT(POST_CNT), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .LEVEL(LEVEL), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 PHI0 = ~PHI0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model: expected FIFO contents as a queue ----------------
  logic [25:0] mq[$];
  string       mode = "idle";
  bit          movf = 1'b0;
  bit          prev_phi2 = 1'b0;
  int          left = 0;

  always @(posedge PHI0) begin
    bit          cap_m, pop_m, push_m, full_m;
    logic [25:0] e;
    cap_m  = prev_phi2 && !PHI2;
    pop_m  = (mq.size() != 0) && OUT_READY;
    e      = {SYNC, RnW, A, D};
    push_m = 1'b0;
    if (RES) begin
      mq.delete();
      mode      = "idle";
      movf      = 1'b0;
      prev_phi2 = 1'b0;
      left      = 0;
    end else begin
      prev_phi2 = PHI2;
      if (ABORT) begin
        mode = "idle";
        if (pop_m) void'(mq.pop_front());
      end else if (ARM) begin
        mq.delete();
        movf = 1'b0;
        if (TRIG_EN) mode = "armed";
        else         mode = "capture";
        left = int'(POST_CNT) + 1;
      end else begin
        if (mode == "armed" && cap_m && SYNC && A == TRIG_ADDR) begin
          push_m = 1'b1;
          if (POST_CNT == 0) begin
            mode = "done";
          end else begin
            mode = "capture";
            left = int'(POST_CNT);
          end
        end else if (mode == "capture" && cap_m) begin
          push_m = 1'b1;
          left--;
          if (left == 0) mode = "done";
        end
        full_m = (mq.size() == Depth);
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
          if (full_m && !pop_m) movf = 1'b1;
          else                  mq.push_back(e);
        end
      end
    end
  end

  // ---------------- Monitor: compares DUT outputs against the model ----------------
  always @(negedge PHI0) begin
    logic [25:0] head;
    head = (mq.size() != 0) ? mq[0] : 26'd0;
    chk("level",     32'(LEVEL),     32'(mq.size()));
    chk("out_valid", 32'(OUT_VALID), 32'(mq.size() != 0));
    chk("out_data",  32'(OUT_DATA),  32'(head));
    chk("busy",      32'(BUSY),      32'(mode == "armed" || mode == "capture"));
    chk("done",      32'(DONE),      32'(mode == "done"));
    chk("ovf",       32'(OVF),       32'(movf));
    if (OUT_VALID && OUT_READY) begin
      if (mq.size() == 0) chk("drain_nonempty", 32'(OUT_VALID), 32'd0);
      else                chk("drain_data", 32'(OUT_DATA), 32'(mq[0]));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge PHI0);
    #2;
    if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                           input logic sync, input logic pop_on_cap);
    A = a; D = d; RnW = rnw; SYNC = sync;
    PHI2 = 1'b1;
    step();
    step();
    PHI2 = 1'b0;
    if (pop_on_cap) OUT_READY = 1'b1;
    step();
    if (pop_on_cap) OUT_READY = 1'b0;
    step();
  endtask

  task automatic arm(input logic trig_en, input logic [7:0] post);
    TRIG_EN = trig_en; POST_CNT = post; ARM = 1'b1;
    step();
    ARM = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    RES = 1'b0;
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_data",  32'(OUT_DATA), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);

    // Free-run, three stored cycles out of five
    arm(1'b0, 8'd2);
    for (int i = 0; i < 5; i++) cpu_cycle(16'h1000 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    chk("free_level", 32'(LEVEL), 32'd3);
    chk("free_done",  32'(DONE), 32'd1);
    chk("free_ovf",   32'(OVF), 32'd0);
    chk("free_head",  32'(OUT_DATA[23:8]), 32'h1000);
    OUT_READY = 1'b1;
    repeat (2) step();
    chk("free_third", 32'(OUT_DATA[23:8]), 32'h1002);
    step();
    OUT_READY = 1'b0;
    chk("free_empty", 32'(OUT_VALID), 32'd0);

    // Trigger on opcode fetch at 0xFFFC with one post cycle
    TRIG_ADDR = 16'hFFFC;
    arm(1'b1, 8'd1);
    cpu_cycle(16'hFFFC, 8'h11, 1'b1, 1'b0, 1'b0);
    cpu_cycle(16'hFFFC, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("trig_nosync_level", 32'(LEVEL), 32'd0);
    chk("trig_armed_busy",   32'(BUSY), 32'd1);
    cpu_cycle(16'hFFFC, 8'hA9, 1'b1, 1'b1, 1'b0);
    cpu_cycle(16'h1234, 8'h55, 1'b0, 1'b0, 1'b0);
    cpu_cycle(16'h1235, 8'h66, 1'b1, 1'b0, 1'b0);
    chk("trig_level", 32'(LEVEL), 32'd2);
    chk("trig_head",  32'(OUT_DATA), 32'({1'b1, 1'b1, 16'hFFFC, 8'hA9}));
    chk("trig_done",  32'(DONE), 32'd1);

    // Trigger with no post cycles
    arm(1'b1, 8'd0);
    cpu_cycle(16'hFFFC, 8'h01, 1'b1, 1'b1, 1'b0);
    cpu_cycle(16'hFFFC, 8'h02, 1'b1, 1'b1, 1'b0);
    chk("trig0_level", 32'(LEVEL), 32'd1);
    chk("trig0_done",  32'(DONE), 32'd1);

    // Overflow: 20 caps into 16 entries
    arm(1'b0, 8'd19);
    for (int i = 1; i <= 20; i++) cpu_cycle(16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_level", 32'(LEVEL), 32'd16);
    chk("ovf_flag",  32'(OVF), 32'd1);
    chk("ovf_done",  32'(DONE), 32'd1);
    chk("ovf_head",  32'(OUT_DATA[23:8]), 32'd1);
    OUT_READY = 1'b1;
    repeat (15) step();
    chk("ovf_last", 32'(OUT_DATA[23:8]), 32'd16);
    step();
    OUT_READY = 1'b0;
    chk("ovf_drained", 32'(LEVEL), 32'd0);

    // Full FIFO with a pop coinciding with the final cap
    arm(1'b0, 8'd16);
    for (int i = 0; i < 16; i++) cpu_cycle(16'h2000 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    chk("fullpop_pre", 32'(LEVEL), 32'd16);
    cpu_cycle(16'h2010, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk("fullpop_level", 32'(LEVEL), 32'd16);
    chk("fullpop_ovf",   32'(OVF), 32'd0);
    chk("fullpop_head",  32'(OUT_DATA[23:8]), 32'h2001);
    OUT_READY = 1'b1;
    repeat (15) step();
    chk("fullpop_newest", 32'(OUT_DATA[23:8]), 32'h2010);
    step();
    OUT_READY = 1'b0;

    // ABORT beats ARM; contents kept
    arm(1'b0, 8'd20);
    for (int i = 0; i < 5; i++) cpu_cycle(16'h3000 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    ABORT = 1'b1; ARM = 1'b1;
    step();
    ABORT = 1'b0; ARM = 1'b0;
    chk("abort_level", 32'(LEVEL), 32'd5);
    chk("abort_busy",  32'(BUSY), 32'd0);
    arm(1'b1, 8'd3);
    chk("rearm_level", 32'(LEVEL), 32'd0);
    chk("rearm_valid", 32'(OUT_VALID), 32'd0);

    // ABORT keeps OVF, the next ARM clears it
    arm(1'b0, 8'd30);
    for (int i = 0; i < 17; i++) cpu_cycle(16'h4000 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("abort_ovf_kept", 32'(OVF), 32'd1);
    arm(1'b0, 8'd3);
    chk("arm_ovf_clear", 32'(OVF), 32'd0);

    // Reset mid-capture with a coincident cap
    arm(1'b0, 8'd20);
    for (int i = 0; i < 7; i++) cpu_cycle(16'h5000 + 16'(i), 8'(i), 1'b1, 1'b0, 1'b0);
    chk("res_pre_level", 32'(LEVEL), 32'd7);
    PHI2 = 1'b1;
    step();
    step();
    PHI2 = 1'b0; RES = 1'b1;
    step();
    chk("res_level", 32'(LEVEL), 32'd0);
    chk("res_valid", 32'(OUT_VALID), 32'd0);
    chk("res_data",  32'(OUT_DATA), 32'd0);
    chk("res_busy",  32'(BUSY), 32'd0);
    chk("res_done",  32'(DONE), 32'd0);
    chk("res_ovf",   32'(OVF), 32'd0);
    RES = 1'b0;
    step();
    chk("res_no_push", 32'(LEVEL), 32'd0);

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        arm(1'($urandom_range(0, 1)), 8'($urandom_range(0, 24)));
      end else if (r < 8) begin
        ABORT = 1'b1;
        if (r == 7) ARM = 1'b1;
        step();
        ABORT = 1'b0; ARM = 1'b0;
      end else if (r < 9) begin
        RES = 1'b1;
        step();
        RES = 1'b0;
      end else begin
        cpu_cycle(($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'b0);
      end
    end
    rand_rdy = 1'b0;
    OUT_READY = 1'b1;
    repeat (20) step();
    chk("final_empty", 32'(LEVEL), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_trace_fifo.md
Name: bus_trace_fifo

Overview:
- Debug capture stage downstream of the 6502 core's external pins.
- Samples A, D, RnW and SYNC once per CPU cycle, on the falling edge of PHI2.
- Optionally waits for an opcode-fetch trigger address, then stores a bounded number of cycles into a FIFO.
- A debugger drains the FIFO through a valid/ready port.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16 by default).

Ports:
- PHI0  in  1  single system clock; all state updates on its rising edge.
- RES  in  1  synchronous, active-high reset.
- PHI2  in  1  CPU phase-2 level, treated as data and edge-detected.
- A  in  16  CPU address bus.
- D  in  8  CPU data bus.
- RnW  in  1  CPU read/write (1 = read).
- SYNC  in  1  CPU opcode-fetch indicator.
- ARM  in  1  one-cycle pulse; starts a new capture.
- ABORT  in  1  one-cycle pulse; stops capture.
- TRIG_EN  in  1  1 = wait for trigger; 0 = free-run.
- TRIG_ADDR  in  16  trigger fetch address.
- POST_CNT  in  8  number of cycles stored after the trigger entry.
- OUT_DATA  out  26  FIFO head: {SYNC, RnW, A[15:0], D[7:0]} in bits [25], [24], [23:8], [7:0].
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts head.
- LEVEL  out  DEPTH_LOG2+1  FIFO occupancy, range 0..DEPTH.
- BUSY  out  1  state is ARMED or CAPTURE.
- DONE  out  1  state is DONE.
- OVF  out  1  sticky flag: an entry was dropped because the FIFO was full.

Behaviour:
- Reset values: state IDLE, FIFO empty, OUT_VALID=0, OUT_DATA=0, LEVEL=0, BUSY=0, DONE=0, OVF=0, phi2_d=0, remaining counter=0.
- Capture strobe: cap = phi2_d & ~PHI2, where phi2_d is PHI2 registered on PHI0.
  - The sample is A/D/RnW/SYNC as seen in the same PHI0 cycle that cap is high.
  - At most one cap per PHI2 low period.
- State IDLE: ignores cap. On ARM: flush FIFO, clear OVF, then go to ARMED if TRIG_EN=1, else CAPTURE with remaining=POST_CNT+1 (9-bit counter).
- State ARMED: on cap with SYNC=1 and A==TRIG_ADDR:
  - push the entry;
  - if POST_CNT=0, go to DONE;
  - otherwise go to CAPTURE with remaining=POST_CNT.
  - Non-matching caps are discarded.
- State CAPTURE: every cap pushes the entry and decrements remaining. When remaining reaches 0 at that cap, go to DONE on the same edge.
- State DONE: holds until ARM, which behaves as from IDLE.
- ARM while in ARMED or CAPTURE restarts: flush FIFO, clear OVF, reload the counter.
- ABORT from any state goes to IDLE and keeps FIFO contents and OVF. ABORT wins over a simultaneous ARM. A cap in the same cycle as ABORT is not stored.
- Push while full:
  - no pop in that cycle: entry dropped, OVF set, remaining still decrements (capture length is measured in CPU cycles, not stored entries);
  - pop in that cycle: push accepted, LEVEL unchanged.
- FIFO is first-word-fall-through:
  - OUT_VALID=(LEVEL!=0);
  - OUT_DATA=head entry, forced to 0 when empty;
  - pop on OUT_VALID & OUT_READY;
  - push and pop in the same cycle leave LEVEL unchanged.
- Push into an empty FIFO becomes visible on OUT_VALID the next cycle (1-cycle latency). OUT_READY while empty has no effect.
- Read/write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Full/empty are derived from LEVEL.
- ARM flush takes priority over a pop in the same cycle. After the flush, LEVEL=0 and OUT_VALID=0 on the next cycle.
- RES mid-capture returns every output to its reset value on the next edge, regardless of other inputs.

Test Plan:
- Free-run: TRIG_EN=0, POST_CNT=2, ARM, 5 PHI2 cycles with A=0x1000..0x1004 → exactly 3 entries (A=0x1000,0x1001,0x1002), DONE=1, LEVEL=3, OVF=0.
- Trigger: TRIG_EN=1, TRIG_ADDR=0xFFFC.
  - Caps with A=0xFFFC and SYNC=0 are ignored.
  - Then A=0xFFFC with SYNC=1, POST_CNT=1 → 2 entries, first = {1,1,0xFFFC,D}.
  - POST_CNT=0 → exactly 1 entry and DONE=1.
- Overflow: DEPTH=16, free-run POST_CNT=19, OUT_READY=0 → LEVEL=16, OVF=1, DONE=1 after 20 caps. Draining yields A of caps 1..16 in order.
- Full with concurrent pop: FIFO full, OUT_READY=1 during a cap → LEVEL stays 16, OVF stays 0, and the newest entry appears last when drained.
- ABORT vs ARM: both asserted during CAPTURE with LEVEL=5 → state IDLE, LEVEL=5, BUSY=0. A subsequent ARM alone → LEVEL=0 next cycle and OVF cleared.
- Reset mid-operation: RES during CAPTURE with LEVEL=7 → next cycle LEVEL=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0, OVF=0, and no push from a coincident cap.
